alu_accumulator: RTL

ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

---
 rtl/alu_accumulator_pkg.sv | 25 ++
 rtl/alu_accumulator_addsub.sv | 25 ++
 rtl/alu_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_accumulator_pkg.sv
// Shared encodings for the accumulator: command codes, FSM states and
// the bit positions of the {N, Z, C, V} flag vector.
package alu_accumulator_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_ADD   = 2'b01,
    CMD_SUB   = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] FLAGS_CLEAR = 4'b0100;

endpackage

// File: rtl/alu_accumulator_addsub.sv
// Combinational WIDTH-bit adder/subtractor. Subtraction is a + ~b + 1, so
// carry_o is the "no borrow" indication and ovf_o is signed overflow.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;

  // Invert b for subtraction and fold the +1 into the carry-in.
  always_comb begin
    b_eff              = sub_i ? ~b_i : b_i;
    {carry_o, sum_o}   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    // Overflow: both effective operands share a sign that the result lacks.
    ovf_o              = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator with a three-state handshake: IDLE captures a command,
// EXEC applies it to the accumulator, DONE presents the result until taken.
module alu_accumulator
  import alu_accumulator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_in,
  input  logic [1:0]       cmd,
  output logic [WIDTH-1:0] acc_out,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sticky_ovf
);

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i     (acc_q),
    .b_i     (res_q),
    .sub_i   (cmd_q == CMD_SUB),
    .sum_o   (as_sum),
    .carry_o (as_carry),
    .ovf_o   (as_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic: one cycle each in IDLE->EXEC->DONE, DONE waits for out_ready.
  always_comb begin
    // NOTE: a default first means every path assigns state_d, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode: only in_ready is combinational, and it depends on state alone.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
  end

  // Datapath next values: capture in IDLE, compute in EXEC, hold otherwise.
  always_comb begin
    cmd_d       = cmd_q;
    res_d       = res_q;
    acc_d       = acc_q;
    flags_d     = flags_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cmd_d = cmd_e'(cmd);
          res_d = res_in;
        end
      end
      ST_EXEC: begin
        out_valid_d = 1'b1;
        unique case (cmd_q)
          CMD_LOAD: begin
            acc_d           = res_q;
            flags_d[FLAG_C] = 1'b0;
            flags_d[FLAG_V] = 1'b0;
          end
          CMD_ADD, CMD_SUB: begin
            acc_d           = as_sum;
            flags_d[FLAG_C] = as_carry;
            flags_d[FLAG_V] = as_ovf;
          end
          CMD_CLEAR: begin
            acc_d           = '0;
            flags_d[FLAG_C] = 1'b0;
            flags_d[FLAG_V] = 1'b0;
          end
          default: ;
        endcase
        flags_d[FLAG_N] = acc_d[WIDTH-1];
        flags_d[FLAG_Z] = (acc_d == '0);
        if (cmd_q == CMD_CLEAR) begin
          flags_d  = FLAGS_CLEAR;
          sticky_d = 1'b0;
        end else if (flags_d[FLAG_V]) begin
          sticky_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= CMD_LOAD;
      res_q       <= '0;
      acc_q       <= '0;
      flags_q     <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out    = acc_q;
  assign flags      = flags_q;
  assign out_valid  = out_valid_q;
  assign sticky_ovf = sticky_q;

endmodule
